// File: rtl/mc_core_if.sv
// mc_core_if: run-control, instruction-fetch and debug signals of mc_core; master = core side, slave = environment side
interface mc_core_if #(
  parameter int W = 8,
  parameter int D = 10
);
  logic         start;
  logic [D-1:0] imem_addr;
  logic [8:0]   imem_data;
  logic [2:0]   dbg_addr;
  logic [W-1:0] dbg_data;
  logic [15:0]  retired;
  logic         done;
  modport master (
    input  start, imem_data, dbg_addr,
    output imem_addr, dbg_data, retired, done
  );
  modport slave (
    output start, imem_data, dbg_addr,
    input  imem_addr, dbg_data, retired, done
  );
endinterface

// File: rtl/mc_core.sv
// mc_core: multi-cycle 9-bit-ISA core with start/done FSM; ports clk, reset, bus (start, imem_addr/imem_data, dbg_addr/dbg_data, retired, done)
module mc_core #(
  parameter int W        = 8,
  parameter int D        = 10,
  parameter int DM_DEPTH = 256,
  parameter int START_PC = 0
) (
  input logic       clk,
  input logic       reset,
  mc_core_if.master bus
);
  localparam int AW = $clog2(DM_DEPTH);
  typedef enum logic [2:0] {IDLE, FETCH, EXEC, MEM, HALT} stateT;
  stateT        state;
  logic [D-1:0] pc;
  logic [8:0]   ir;
  logic [W-1:0] regs [8];
  logic [W-1:0] dm [DM_DEPTH];
  logic [15:0]  retiredCnt;
  logic         doneR;
  logic [2:0]   op, ra, rb;
  logic [W-1:0] raVal, rbVal, aluRes;
  logic [AW-1:0] memAddr;
  logic [D-1:0] pcInc, pcExec;
  logic         isHalt, isMem, writesReg;
  assign op        = ir[8:6];
  assign ra        = ir[5:3];
  assign rb        = ir[2:0];
  assign raVal     = regs[ra];
  assign rbVal     = regs[rb];
  assign memAddr   = AW'(rbVal);
  assign pcInc     = pc + D'(1);
  assign isHalt    = op == 3'd7 && ir[5:0] == 6'd0;
  assign isMem     = op == 3'd5 || op == 3'd6;
  assign writesReg = op == 3'd0 || op == 3'd2 || op == 3'd3 || op == 3'd4;
  always_comb begin
    aluRes = op == 3'd0 ? raVal ^ rbVal
           : op == 3'd2 ? raVal + W'($signed(ir[2:0]))
           : op == 3'd3 ? raVal & W'(ir[2:0])
           : raVal << ir[2:0];
    pcExec = op == 3'd1 ? (raVal == '0 ? pc + D'($signed(ir[2:0])) : pcInc)
           : op == 3'd7 ? pc + D'($signed(ir[5:0]))
           : pcInc;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      pc         <= D'(START_PC);
      ir         <= '0;
      retiredCnt <= '0;
      doneR      <= 1'b0;
      for (int i = 0; i < 8; i++) regs[i] <= '0;
      for (int i = 0; i < DM_DEPTH; i++) dm[i] <= '0;
    end else begin
      case (state)
        IDLE, HALT: if (bus.start) begin
          state      <= FETCH;
          pc         <= D'(START_PC);
          retiredCnt <= '0;
          doneR      <= 1'b0;
        end
        FETCH: begin
          ir    <= bus.imem_data;
          state <= EXEC;
        end
        EXEC: if (isHalt) begin
          state <= HALT;
          doneR <= 1'b1;
        end else if (isMem) begin
          state <= MEM;
        end else begin
          if (writesReg) regs[ra] <= aluRes;
          pc         <= pcExec;
          retiredCnt <= retiredCnt + 16'd1;
          state      <= FETCH;
        end
        MEM: begin
          if (op == 3'd6) dm[memAddr] <= raVal;
          else regs[ra] <= dm[memAddr];
          pc         <= pcInc;
          retiredCnt <= retiredCnt + 16'd1;
          state      <= FETCH;
        end
        default: state <= IDLE;
      endcase
    end
  end
  assign bus.imem_addr = pc;
  assign bus.dbg_data  = regs[bus.dbg_addr];
  assign bus.retired   = retiredCnt;
  assign bus.done      = doneR;
endmodule

// File: tb/tb_mc_core.sv
// tb_mc_core: randomized program runs against an ISA-level model, scoreboard checked on each done rise
`timescale 1ns/1ps
module tb_mc_core;
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #10 clk = ~clk;
  mc_core_if #(.W(8), .D(10)) bus();
  mc_core_if #(.W(4), .D(4))  bus2();
  mc_core #(.W(8), .D(10), .DM_DEPTH(256), .START_PC(0))
    dut (.clk(clk), .reset(reset), .bus(bus));
  mc_core #(.W(4), .D(4), .DM_DEPTH(16), .START_PC(15))
    dut2 (.clk(clk), .reset(reset), .bus(bus2));
  typedef struct {
    int tStart;
    int cycles;
    int retired;
    bit halted;
    logic [7:0][7:0] regs;
  } expT;
  logic [8:0] rom [1024];
  logic [8:0] rom2 [16];
  logic [2:0] stimSel = '0, monSel = '0, sel2 = '0;
  logic       monActive = 1'b0;
  assign bus.imem_data  = rom[bus.imem_addr];
  assign bus.dbg_addr   = monActive ? monSel : stimSel;
  assign bus2.imem_data = rom2[bus2.imem_addr];
  assign bus2.dbg_addr  = sel2;
  int   cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;
  int   checks = 0, failures = 0, monChecked = 0;
  expT  q[$];
  int   mregs [8];
  int   mdm [256];
  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at cycle %0d", name, act, exp, cyc);
    end
  endtask
  function automatic void modelClear();
    for (int i = 0; i < 8; i++) mregs[i] = 0;
    for (int i = 0; i < 256; i++) mdm[i] = 0;
  endfunction
  function automatic void clearRom();
    for (int i = 0; i < 1024; i++) rom[i] = 9'b111_000000;
  endfunction
  function automatic logic [8:0] gen();
    logic [2:0] op;
    logic [5:0] f;
    op = 3'($urandom_range(0, 7));
    f  = 6'($urandom);
    if (op == 3'd1) f[2:0] = 3'($urandom_range(1, 3));
    if (op == 3'd7) f = 6'($urandom_range(1, 3));
    return {op, f};
  endfunction
  // Architectural interpreter: one loop iteration per instruction, costs in cycles per instruction class
  function automatic expT model();
    expT e;
    int pc, npc, op, a, b, s3, s6;
    logic [8:0] ins;
    pc = 0; e.tStart = 0; e.cycles = 0; e.retired = 0; e.halted = 0;
    for (int s = 0; s < 5000 && !e.halted; s++) begin
      ins = rom[pc];
      op = int'(ins[8:6]); a = int'(ins[5:3]); b = int'(ins[2:0]);
      s3 = b > 3 ? b - 8 : b;
      s6 = int'(ins[5:0]);
      if (s6 > 31) s6 -= 64;
      npc = pc + 1;
      if (op == 7 && s6 == 0) begin
        e.cycles += 2;
        e.halted = 1;
      end else begin
        case (op)
          0: mregs[a] = mregs[a] ^ mregs[b];
          1: if (mregs[a] == 0) npc = pc + s3;
          2: mregs[a] = (mregs[a] + s3) & 255;
          3: mregs[a] = mregs[a] & b;
          4: mregs[a] = (mregs[a] << b) & 255;
          5: mregs[a] = mdm[mregs[b]];
          6: mdm[mregs[b]] = mregs[a];
          default: npc = pc + s6;
        endcase
        e.cycles += (op == 5 || op == 6) ? 3 : 2;
        e.retired++;
        pc = npc & 1023;
      end
    end
    for (int r = 0; r < 8; r++) e.regs[r] = 8'(mregs[r]);
    return e;
  endfunction
  initial begin : monitor
    expT e;
    logic prevDone;
    prevDone = 1'b0;
    forever begin
      @(negedge clk);
      if (bus.done && !prevDone) begin
        if (q.size() == 0) chk("unexpected_done", 1, 0);
        else begin
          e = q.pop_front();
          chk("halt_cycle", cyc - e.tStart, e.cycles);
          chk("retired", bus.retired, e.retired);
          monActive = 1'b1;
          for (int r = 0; r < 8; r++) begin
            monSel = 3'(r);
            #1;
            chk($sformatf("reg%0d", r), bus.dbg_data, e.regs[r]);
          end
          monActive = 1'b0;
        end
        monChecked++;
      end
      prevDone = bus.done;
    end
  end
  task automatic checkClean(input string tag);
    chk({tag, "_done"}, bus.done, 0);
    chk({tag, "_pc"}, bus.imem_addr, 0);
    chk({tag, "_retired"}, bus.retired, 0);
    chk({tag, "_pc2"}, bus2.imem_addr, 15);
    for (int r = 0; r < 8; r++) begin
      stimSel = 3'(r);
      #1;
      chk($sformatf("%s_reg%0d", tag, r), bus.dbg_data, 0);
    end
  endtask
  task automatic doReset(input string tag);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    checkClean(tag);
    reset = 1'b0;
    modelClear();
  endtask
  task automatic run(input bit poke);
    expT e;
    int target, n;
    logic wasHalt;
    e = model();
    target = monChecked + 1;
    @(negedge clk);
    wasHalt = bus.done;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    e.tStart = cyc;
    q.push_back(e);
    if (wasHalt) chk("done_fall", bus.done, 0);
    if (poke) begin
      @(negedge clk);
      bus.start = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
    end
    n = 0;
    while (monChecked < target && n < 3000) begin
      @(negedge clk);
      n++;
    end
    if (monChecked < target) begin
      chk("halt_timeout", 0, 1);
      q.delete();
    end
  endtask
  initial begin : stim
    int t, n;
    bus.start = 1'b0;
    bus2.start = 1'b0;
    clearRom();
    for (int i = 0; i < 16; i++) rom2[i] = 9'b111_000000;
    rom2[15] = 9'b010_001_001;
    rom2[0]  = 9'b100_001_111;
    doReset("rst_init");
    @(negedge clk);
    bus2.start = 1'b1;
    @(negedge clk);
    bus2.start = 1'b0;
    t = cyc;
    repeat (2) @(negedge clk);
    chk("w4_pc_wrap", bus2.imem_addr, 0);
    chk("w4_retired1", bus2.retired, 1);
    sel2 = 3'd1;
    #1;
    chk("w4_r1_addi", bus2.dbg_data, 1);
    n = 0;
    while (!bus2.done && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("w4_halt_cycle", cyc - t, 6);
    chk("w4_retired", bus2.retired, 2);
    #1;
    chk("w4_r1_ls", bus2.dbg_data, 0);
    rom[0] = 9'b010_001_011; rom[1] = 9'b010_010_111;
    rom[2] = 9'b000_001_010; rom[3] = 9'b111_000000;
    run(1'b0);
    doReset("rst_p2");
    clearRom();
    rom[0] = 9'b010_001_101; rom[1] = 9'b010_010_010;
    rom[2] = 9'b110_001_010; rom[3] = 9'b101_011_010;
    run(1'b1);
    doReset("rst_p3");
    clearRom();
    rom[0] = 9'b010_001_011; rom[1] = 9'b010_001_111;
    rom[2] = 9'b001_001_010; rom[3] = 9'b111_111110;
    run(1'b0);
    run(1'b1);
    doReset("rst_p4");
    clearRom();
    rom[0] = 9'b010_001_101; rom[1] = 9'b010_010_010;
    rom[2] = 9'b110_001_010; rom[3] = 9'b101_011_010;
    @(negedge clk);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    t = cyc;
    while (cyc < t + 6) @(negedge clk);
    reset = 1'b1;
    bus.start = 1'b1;
    @(negedge clk);
    checkClean("rst_mem");
    reset = 1'b0;
    bus.start = 1'b0;
    modelClear();
    repeat (3) @(negedge clk);
    chk("idle_pc", bus.imem_addr, 0);
    chk("idle_retired", bus.retired, 0);
    chk("idle_done", bus.done, 0);
    clearRom();
    rom[0] = 9'b010_010_010; rom[1] = 9'b101_011_010;
    run(1'b0);
    for (int k = 0; k < 30; k++) begin
      clearRom();
      n = $urandom_range(4, 12);
      for (int i = 0; i < n; i++) rom[i] = gen();
      run($urandom_range(0, 3) == 0);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
